rf_writeback_queue: RTL

Write-side front end of the RV32 integer register file. Accepts completed results from the ALU and load/store unit over valid/ready channels, buffers them in a small in-order queue, and drives the register file write port one result per cycle. Also answers decode-stage source-operand lookups so that decode can detect, or optionally bypass, results that have not yet reached the register file.

---
 rtl/rf_writeback_queue.sv | 127 ++++++++++++
 1 files changed

// File: rtl/rf_writeback_queue.sv
// Register-file write-side queue: buffers ALU/LSU results in order,
// drives one RF write per cycle and answers decode source lookups.
// Ports: alu_*/lsu_* valid/ready producers (LSU has priority), wb_stall,
//   rf_we/rf_waddr/rf_wdata write port, rsN_addr -> rsN_hit/rsN_fwd, count.
// Build option: RF_WB_BYPASS_EN enables data forwarding on rsN_fwd.
module rf_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [4:0]               alu_rd,
  input  logic [XLEN-1:0]          alu_data,
  input  logic                     lsu_valid,
  output logic                     lsu_ready,
  input  logic [4:0]               lsu_rd,
  input  logic [XLEN-1:0]          lsu_data,
  input  logic                     wb_stall,
  output logic                     rf_we,
  output logic [4:0]               rf_waddr,
  output logic [XLEN-1:0]          rf_wdata,
  input  logic [4:0]               rs1_addr,
  input  logic [4:0]               rs2_addr,
  output logic                     rs1_hit,
  output logic                     rs2_hit,
  output logic [XLEN-1:0]          rs1_fwd,
  output logic [XLEN-1:0]          rs2_fwd,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr, rptr;
  logic [4:0]       rd_q  [DEPTH];
  logic [XLEN-1:0]  dat_q [DEPTH];
  logic             full, empty;
  logic             lsu_take, alu_take;
  logic             push, pop;
  logic [4:0]       in_rd;
  logic [XLEN-1:0]  in_data;
  logic [AW-1:0]    idx;

  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);
  assign count = wptr - rptr;

  // Ready depends only on registered fullness, never on a same-cycle pop.
  assign lsu_ready = !full;
  assign alu_ready = !full && !lsu_valid;

  assign lsu_take = lsu_valid && lsu_ready;
  assign alu_take = alu_valid && alu_ready;
  assign in_rd    = lsu_take ? lsu_rd   : alu_rd;
  assign in_data  = lsu_take ? lsu_data : alu_data;
  // x0 writes complete the handshake but are dropped.
  assign push     = (lsu_take || alu_take) && (in_rd != 5'd0);
  assign pop      = !empty && !wb_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]  <= '0;
        dat_q[i] <= '0;
      end
    end else begin
      if (push) begin
        rd_q[wptr[AW-1:0]]  <= in_rd;
        dat_q[wptr[AW-1:0]] <= in_data;
        wptr                <= wptr + (AW+1)'(1);
      end
      rf_we <= pop;
      if (pop) begin
        rf_waddr <= rd_q[rptr[AW-1:0]];
        rf_wdata <= dat_q[rptr[AW-1:0]];
        rptr     <= rptr + (AW+1)'(1);
      end
    end
  end

  // Scan oldest->youngest so the youngest match is the last to win;
  // the output register is older than any queued entry.
  always_comb begin
    rs1_hit = 1'b0;
    rs2_hit = 1'b0;
    rs1_fwd = '0;
    rs2_fwd = '0;
    idx     = '0;
    if (rf_we && rs1_addr != 5'd0 && rf_waddr == rs1_addr) begin
      rs1_hit = 1'b1;
`ifdef RF_WB_BYPASS_EN
      rs1_fwd = rf_wdata;
`endif
    end
    if (rf_we && rs2_addr != 5'd0 && rf_waddr == rs2_addr) begin
      rs2_hit = 1'b1;
`ifdef RF_WB_BYPASS_EN
      rs2_fwd = rf_wdata;
`endif
    end
    for (int k = 0; k < DEPTH; k++) begin
      idx = rptr[AW-1:0] + AW'(k);
      if ((AW+1)'(k) < count) begin
        if (rs1_addr != 5'd0 && rd_q[idx] == rs1_addr) begin
          rs1_hit = 1'b1;
`ifdef RF_WB_BYPASS_EN
          rs1_fwd = dat_q[idx];
`endif
        end
        if (rs2_addr != 5'd0 && rd_q[idx] == rs2_addr) begin
          rs2_hit = 1'b1;
`ifdef RF_WB_BYPASS_EN
          rs2_fwd = dat_q[idx];
`endif
        end
      end
    end
  end

endmodule
